// File: rtl/adc_push_scheduler.sv
// adc_push_scheduler: buffers ADC samples and paces pushADC onto the shared channel bus
module adc_push_scheduler #(
    parameter int DEPTH   = 16,
    parameter int MIN_GAP = 4,
    parameter int LW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adc_strobe,
    input  logic [15:0]   adc_data,
    input  logic [31:0]   addr,
    input  logic [31:0]   Wdata,
    input  logic          write,
    input  logic          read,
    output logic [31:0]   Rdata,
    output logic [15:0]   ADC,
    output logic          pushADC,
    output logic [LW-1:0] level,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    gap_q, gap_d;
    logic [7:0]    drop_q, drop_d;
    logic          run_q, run_d, ovf_q, ovf_d;
    logic          empty, full, sel_run, sel_stat, sel_cfg, clr, flush, pop, accept, drop;
    logic          unused_bits;
    assign unused_bits = ^{addr[31:16], Wdata[31:17], Wdata[15:1]};
    assign sel_run  = addr[15:0] == 16'h0100;
    assign sel_stat = addr[15:0] == 16'h0180;
    assign sel_cfg  = addr[15:0] == 16'h0184;
    assign empty    = level_q == '0;
    assign full     = level_q == LW'(DEPTH);
    assign clr      = write & sel_stat & Wdata[16];
    assign flush    = write & sel_cfg & Wdata[0];
    // a bus access in the same cycle vetoes the push so channels see an idle bus
    assign pushADC  = run_q & ~empty & (gap_q == 4'd0) & ~read & ~write;
    assign pop      = pushADC;
    // a full FIFO still takes the sample when the head leaves in the same cycle
    assign accept   = adc_strobe & ~flush & (~full | pop);
    assign drop     = adc_strobe & ~flush & full & ~pop;
    assign ADC      = empty ? 16'd0 : mem_q[rd_ptr_q];
    assign level    = level_q;
    assign ovf      = ovf_q;
    // next-state for pointers, occupancy, push spacing and status
    always_comb begin
        wr_ptr_d = flush ? '0 : accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = flush ? '0 : level_q + LW'(accept) - LW'(pop);
        gap_d    = flush ? 4'd0 : pop ? 4'(MIN_GAP - 1) : (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
        run_d    = (write & sel_run) ? Wdata[0] : run_q;
        ovf_d    = clr ? 1'b0 : drop ? 1'b1 : ovf_q;
        drop_d   = clr ? 8'd0 : (drop & (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end
    // register read mux; zero unless this block's status/config address is read
    always_comb begin
        Rdata = '0;
        if (read & sel_stat) begin
            Rdata[LW-1:0] = level_q;
            Rdata[8]      = empty;
            Rdata[9]      = full;
            Rdata[16]     = ovf_q;
            Rdata[31:24]  = drop_q;
        end else if (read & sel_cfg) begin
            Rdata[3:0]    = 4'(MIN_GAP);
            Rdata[15:8]   = 8'(AW);
        end
    end
    // sample storage, written only when a sample is accepted
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= adc_data;
    end
    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            gap_q    <= '0;
            run_q    <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            gap_q    <= gap_d;
            run_q    <= run_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end
endmodule

// File: tb/tb_adc_push_scheduler.sv
// tb_adc_push_scheduler: directed stimulus checked against a queue-based model every cycle
module tb_adc_push_scheduler;
    localparam int DEPTH = 16, MIN_GAP = 4, LW = 5;
    logic clk = 1'b0, rst = 1'b1, adc_strobe = 1'b0, write = 1'b0, read = 1'b0;
    logic [15:0] adc_data = '0;
    logic [31:0] addr = '0, Wdata = '0;
    logic [31:0] Rdata;
    logic [15:0] ADC;
    logic pushADC, ovf;
    logic [LW-1:0] level;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    adc_push_scheduler #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .LW(LW)) dut (
        .clk(clk), .rst(rst), .adc_strobe(adc_strobe), .adc_data(adc_data),
        .addr(addr), .Wdata(Wdata), .write(write), .read(read),
        .Rdata(Rdata), .ADC(ADC), .pushADC(pushADC), .level(level), .ovf(ovf));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: sample queue, cycles since last push, run/ovf/drop count
    logic [15:0] mq[$];
    int since = MIN_GAP, m_drop = 0;
    bit m_run = 0, m_ovf = 0;
    always @(negedge clk) begin
        logic e_push;
        logic [31:0] e_rd;
        logic [15:0] a;
        bit fl, cl, dr;
        int sz;
        if (rst) begin
            mq.delete();
            since = MIN_GAP;
            m_run = 0;
            m_ovf = 0;
            m_drop = 0;
        end
        a = addr[15:0];
        sz = mq.size();
        e_push = !rst && m_run && sz > 0 && since >= MIN_GAP && !read && !write;
        e_rd = 0;
        if (read && a == 16'h0180)
            e_rd = {8'(m_drop), 7'd0, m_ovf, 6'd0, sz == DEPTH, sz == 0, 3'd0, 5'(sz)};
        else if (read && a == 16'h0184)
            e_rd = 32'(MIN_GAP) | (32'($clog2(DEPTH)) << 8);
        chk("pushADC", pushADC, e_push);
        chk("ADC", ADC, sz > 0 ? mq[0] : 16'd0);
        chk("level", level, 32'(sz));
        chk("ovf", ovf, m_ovf);
        chk("Rdata", Rdata, e_rd);
        if (!rst) begin
            if (write && a == 16'h0100) m_run = Wdata[0];
            fl = write && a == 16'h0184 && Wdata[0];
            cl = write && a == 16'h0180 && Wdata[16];
            dr = 0;
            if (fl) begin
                mq.delete();
                since = MIN_GAP;
            end else begin
                if (e_push) mq.delete(0);
                since = e_push ? 1 : (since < MIN_GAP ? since + 1 : since);
                if (adc_strobe) begin
                    if (sz < DEPTH || e_push) mq.push_back(adc_data);
                    else dr = 1;
                end
            end
            if (cl) begin
                m_ovf = 0;
                m_drop = 0;
            end else if (dr) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; Wdata = d;
        tick();
        write = 1'b0; addr = '0; Wdata = '0;
    endtask
    task automatic strobe(input logic [15:0] d);
        adc_strobe = 1'b1; adc_data = d;
        tick();
        adc_strobe = 1'b0;
    endtask
    task automatic rd_stat(input string name, input logic [31:0] exp);
        read = 1'b1; addr = 32'h0180;
        #1 chk(name, Rdata, exp);
        read = 1'b0; addr = '0;
    endtask
    initial begin
        logic [15:0] got[$];
        #1;
        chk("rst pushADC", pushADC, 0);
        chk("rst ADC", ADC, 0);
        chk("rst level", level, 0);
        chk("rst ovf", ovf, 0);
        chk("rst Rdata", Rdata, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        // basic push with spacing
        bus_wr(32'h0100, 1);
        adc_strobe = 1'b1; adc_data = 16'h1234;
        tick();
        adc_data = 16'h8001;
        #1 chk("first push", pushADC, 1);
        chk("first ADC", ADC, 16'h1234);
        tick();
        adc_strobe = 1'b0;
        #1 chk("gap0 push", pushADC, 0);
        chk("gap0 ADC", ADC, 16'h8001);
        repeat (2) begin
            tick();
            #1 chk("gap push", pushADC, 0);
        end
        tick();
        #1 chk("second push", pushADC, 1);
        chk("second ADC", ADC, 16'h8001);
        tick();
        #1 chk("drained level", level, 0);
        // read veto then write veto
        for (int v = 0; v < 2; v++) begin
            repeat (4) tick();
            strobe(16'h00AA);
            if (v == 0) begin read = 1'b1; addr = 32'h0180; end
            else begin write = 1'b1; addr = 32'h0200; end
            #1 chk("veto push", pushADC, 0);
            if (v == 0) chk("veto Rdata", Rdata, 32'h1);
            repeat (2) begin
                tick();
                #1 chk("veto push", pushADC, 0);
            end
            tick();
            read = 1'b0; write = 1'b0; addr = '0;
            #1 chk("retry push", pushADC, 1);
            chk("retry ADC", ADC, 16'h00AA);
            tick();
        end
        read = 1'b1; addr = 32'h0184;
        #1 chk("cfg read", Rdata, 32'h0404);
        addr = 32'h0100;
        #1 chk("run read", Rdata, 0);
        read = 1'b0; addr = '0;
        // overflow with run off, then drain
        bus_wr(32'h0100, 0);
        for (int i = 0; i < DEPTH + 3; i++) strobe(16'(i));
        #1 chk("ovf level", level, 16);
        chk("ovf flag", ovf, 1);
        rd_stat("ovf stat", 32'h03010210);
        bus_wr(32'h0180, 32'h0000FFFF);
        #1 chk("no clear", ovf, 1);
        bus_wr(32'h0100, 1);
        for (int k = 0; k < 80; k++) begin
            #1 if (pushADC) got.push_back(ADC);
            tick();
        end
        chk("push count", got.size(), 16);
        chk("first drained", got.size() > 0 ? got[0] : 16'hDEAD, 0);
        chk("last drained", got.size() > 0 ? got[got.size() - 1] : 16'hDEAD, 15);
        bus_wr(32'h0180, 32'h00010000);
        #1 chk("cleared ovf", ovf, 0);
        rd_stat("cleared stat", 32'h00000100);
        // full with simultaneous pop
        bus_wr(32'h0100, 0);
        for (int i = 0; i < DEPTH; i++) strobe(16'(16'h0100 + i));
        bus_wr(32'h0100, 1);
        adc_strobe = 1'b1; adc_data = 16'h0BEE;
        #1 chk("full pop push", pushADC, 1);
        tick();
        adc_strobe = 1'b0;
        #1 chk("full pop level", level, 16);
        rd_stat("full pop stat", 32'h00000210);
        bus_wr(32'h0100, 0);
        // flush beats strobe
        bus_wr(32'h0184, 1);
        for (int i = 0; i < 5; i++) strobe(16'(16'h0050 + i));
        #1 chk("queued level", level, 5);
        write = 1'b1; addr = 32'h0184; Wdata = 1; adc_strobe = 1'b1; adc_data = 16'h0077;
        tick();
        write = 1'b0; addr = '0; Wdata = '0; adc_strobe = 1'b0;
        #1 chk("flush level", level, 0);
        chk("flush push", pushADC, 0);
        rd_stat("flush stat", 32'h00000100);
        bus_wr(32'h0100, 1);
        repeat (4) tick();
        bus_wr(32'h0100, 0);
        // drop counter saturation and clear-beats-drop
        for (int i = 0; i < DEPTH + 300; i++) strobe(16'(i));
        rd_stat("sat stat", 32'hFF010210);
        write = 1'b1; addr = 32'h0180; Wdata = 32'h00010000; adc_strobe = 1'b1;
        tick();
        write = 1'b0; addr = '0; Wdata = '0; adc_strobe = 1'b0;
        rd_stat("clear wins", 32'h00000210);
        strobe(16'h0001);
        rd_stat("one drop", 32'h01010210);
        // asynchronous reset mid-stream
        rst = 1'b1;
        #1 chk("async level", level, 0);
        chk("async ovf", ovf, 0);
        chk("async ADC", ADC, 0);
        chk("async push", pushADC, 0);
        chk("async Rdata", Rdata, 0);
        tick();
        rst = 1'b0;
        #1 chk("release push", pushADC, 0);
        rd_stat("release stat", 32'h00000100);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
